// File: rtl/pc_fetch_pkg.sv
// Shared types and constants for the IF-stage program counter / fetch unit.
package pc_fetch_pkg;

   typedef enum logic [1:0] {PC_BOOT, PC_RUN, PC_HALT} pc_state_t;

   localparam int DEFAULT_INST_BYTES = 4;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC priority mux: trap > redirect > sequential fire > hold.
// Build option PC_MISALIGN_TRAP_EN: a misaligned redirect target is refused
// (pc holds and misalign is raised) instead of being silently aligned.
module pc_next_sel #(
   parameter int XLEN       = 32,
   parameter int INST_BYTES = 4
) (
   input  logic [XLEN-1:0] pc,
   input  logic            fire,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_target,
   input  logic            trap_valid,
   input  logic [XLEN-1:0] trap_vector,
`ifdef PC_MISALIGN_TRAP_EN
   output logic            misalign,
`endif
   output logic            flush,
   output logic [XLEN-1:0] pc_next
);

   localparam logic [XLEN-1:0] STEP = XLEN'(INST_BYTES);

`ifndef PC_MISALIGN_TRAP_EN
   logic [XLEN-1:0] target_aligned;
   assign target_aligned = {redirect_target[XLEN-1:2], 2'b00};
`endif

   // Select the next PC; any trap or redirect also flushes the IF output
   always_comb begin
      pc_next = pc;
      flush   = trap_valid | redirect_valid;
`ifdef PC_MISALIGN_TRAP_EN
      misalign = 1'b0;
      if (trap_valid) begin
         pc_next = trap_vector;
      end else if (redirect_valid) begin
         if (redirect_target[1:0] != 2'b00) begin
            misalign = 1'b1;
         end else begin
            pc_next = redirect_target;
         end
      end else if (fire) begin
         pc_next = pc + STEP;
      end
`else
      if (trap_valid) begin
         pc_next = trap_vector;
      end else if (redirect_valid) begin
         pc_next = target_aligned;
      end else if (fire) begin
         pc_next = pc + STEP;
      end
`endif
   end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction-fetch request generator for the IF stage.
// Build option PC_MISALIGN_TRAP_EN adds misalign_exc / misalign_addr outputs.
module pc_fetch_unit
   import pc_fetch_pkg::*;
#(
   parameter int              XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = '0,
   parameter int              INST_BYTES   = DEFAULT_INST_BYTES
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            stall,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_target,
   input  logic            trap_valid,
   input  logic [XLEN-1:0] trap_vector,
   input  logic            halt,
   input  logic            resume,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_addr,
   output logic [XLEN-1:0] if_pc,
   output logic            if_valid,
`ifdef PC_MISALIGN_TRAP_EN
   output logic            misalign_exc,
   output logic [XLEN-1:0] misalign_addr,
`endif
   output logic            halted
);

   pc_state_t       state_reg;
   logic [XLEN-1:0] pc_reg;
   logic [XLEN-1:0] pc_next;
   logic [XLEN-1:0] if_pc_reg;
   logic            if_valid_reg;
   logic            halted_reg;
   logic            fire;
   logic            flush;
`ifdef PC_MISALIGN_TRAP_EN
   logic            misalign;
   logic            misalign_exc_reg;
   logic [XLEN-1:0] misalign_addr_reg;
`endif

   // Requests only go out in RUN and are withheld during a hazard stall;
   // the address is the PC register itself, so it cannot move until fire/redirect
   assign imem_req_valid = (state_reg == PC_RUN) & ~stall;
   assign fire           = imem_req_valid & imem_req_ready;
   assign imem_addr      = pc_reg;
   assign if_pc          = if_pc_reg;
   assign if_valid       = if_valid_reg;
   assign halted         = halted_reg;
`ifdef PC_MISALIGN_TRAP_EN
   assign misalign_exc   = misalign_exc_reg;
   assign misalign_addr  = misalign_addr_reg;
`endif

   pc_next_sel #(
      .XLEN       (XLEN),
      .INST_BYTES (INST_BYTES)
   ) u_next_sel (
      .pc              (pc_reg),
      .fire            (fire),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .trap_valid      (trap_valid),
      .trap_vector     (trap_vector),
`ifdef PC_MISALIGN_TRAP_EN
      .misalign        (misalign),
`endif
      .flush           (flush),
      .pc_next         (pc_next)
   );

   // Run-control FSM: one BOOT cycle, then RUN/HALT; halted is a registered copy
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg  <= PC_BOOT;
         halted_reg <= 1'b0;
      end else begin
         case (state_reg)
            PC_BOOT: begin
               state_reg  <= PC_RUN;
               halted_reg <= 1'b0;
            end
            PC_RUN: begin
               if (halt) begin
                  state_reg  <= PC_HALT;
                  halted_reg <= 1'b1;
               end
            end
            PC_HALT: begin
               if (resume) begin
                  state_reg  <= PC_RUN;
                  halted_reg <= 1'b0;
               end
            end
            default: begin
               state_reg  <= PC_BOOT;
               halted_reg <= 1'b0;
            end
         endcase
      end
   end

   // PC register; redirects and traps load regardless of run state or stall
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_reg <= RESET_VECTOR;
      end else begin
         pc_reg <= pc_next;
      end
   end

   // IF/ID handoff: flush beats a new fetch, stall freezes, otherwise bubble
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         if_pc_reg    <= '0;
         if_valid_reg <= 1'b0;
      end else if (flush) begin
         if_valid_reg <= 1'b0;
      end else if (fire) begin
         if_pc_reg    <= pc_reg;
         if_valid_reg <= 1'b1;
      end else if (!stall) begin
         if_valid_reg <= 1'b0;
      end
   end

`ifdef PC_MISALIGN_TRAP_EN
   // One-cycle exception pulse with the refused target captured for the trap handler
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         misalign_exc_reg  <= 1'b0;
         misalign_addr_reg <= '0;
      end else begin
         misalign_exc_reg <= misalign;
         if (misalign) begin
            misalign_addr_reg <= redirect_target;
         end
      end
   end
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed testbench for pc_fetch_unit (default build and PC_MISALIGN_TRAP_EN build).
module tb_pc_fetch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_target;
   logic        trap_valid;
   logic [31:0] trap_vector;
   logic        halt;
   logic        resume;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_addr;
   logic [31:0] if_pc;
   logic        if_valid;
   logic        halted;
`ifdef PC_MISALIGN_TRAP_EN
   logic        misalign_exc;
   logic [31:0] misalign_addr;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pc_fetch_unit #(
      .XLEN         (32),
      .RESET_VECTOR (32'h0),
      .INST_BYTES   (4)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .stall           (stall),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .trap_valid      (trap_valid),
      .trap_vector     (trap_vector),
      .halt            (halt),
      .resume          (resume),
      .imem_req_valid  (imem_req_valid),
      .imem_req_ready  (imem_req_ready),
      .imem_addr       (imem_addr),
      .if_pc           (if_pc),
      .if_valid        (if_valid),
`ifdef PC_MISALIGN_TRAP_EN
      .misalign_exc    (misalign_exc),
      .misalign_addr   (misalign_addr),
`endif
      .halted          (halted)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One-cycle redirect pulse to a target
   task automatic do_redirect(input logic [31:0] target);
      redirect_valid  = 1'b1;
      redirect_target = target;
      tick();
      redirect_valid  = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
      trap_valid = 1'b0; trap_vector = '0; halt = 1'b0; resume = 1'b0;
      imem_req_ready = 1'b1;
      tick(); tick();
      checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid got %b exp 0", imem_req_valid); end
      checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr got %h exp 00000000", imem_addr); end
      checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL rst_if_valid got %b exp 0", if_valid); end
      checks++; if (if_pc !== 32'h0) begin errors++; $display("FAIL rst_if_pc got %h exp 00000000", if_pc); end
      checks++; if (halted !== 1'b0) begin errors++; $display("FAIL rst_halted got %b exp 0", halted); end
      $display("test_reset: done");
   endtask

   task automatic test_sequential();
      reset = 1'b1;
      #1;
      checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL boot_no_req got %b exp 0", imem_req_valid); end
      tick();
      checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL seq0 got v=%b a=%h exp v=1 a=00000000", imem_req_valid, imem_addr); end
      tick();
      checks++; if (imem_addr !== 32'h4 || if_pc !== 32'h0 || if_valid !== 1'b1) begin errors++; $display("FAIL seq4 got a=%h ifpc=%h ifv=%b exp a=4 ifpc=0 ifv=1", imem_addr, if_pc, if_valid); end
      tick();
      checks++; if (imem_addr !== 32'h8 || if_pc !== 32'h4 || if_valid !== 1'b1) begin errors++; $display("FAIL seq8 got a=%h ifpc=%h ifv=%b exp a=8 ifpc=4 ifv=1", imem_addr, if_pc, if_valid); end
      tick();
      checks++; if (imem_addr !== 32'hC || if_pc !== 32'h8) begin errors++; $display("FAIL seqC got a=%h ifpc=%h exp a=c ifpc=8", imem_addr, if_pc); end
      $display("test_sequential: done");
   endtask

   task automatic test_backpressure();
      tick();
      checks++; if (imem_addr !== 32'h10) begin errors++; $display("FAIL bp_start got a=%h exp 10", imem_addr); end
      imem_req_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (imem_addr !== 32'h10 || imem_req_valid !== 1'b1 || if_valid !== 1'b0) begin errors++; $display("FAIL bp_hold%0d got a=%h v=%b ifv=%b exp a=10 v=1 ifv=0", i, imem_addr, imem_req_valid, if_valid); end
      end
      imem_req_ready = 1'b1;
      tick();
      checks++; if (imem_addr !== 32'h14 || if_pc !== 32'h10 || if_valid !== 1'b1) begin errors++; $display("FAIL bp_release got a=%h ifpc=%h ifv=%b exp a=14 ifpc=10 ifv=1", imem_addr, if_pc, if_valid); end
      $display("test_backpressure: done");
   endtask

   task automatic test_trap_redirect();
      trap_valid = 1'b1; trap_vector = 32'h80;
      redirect_valid = 1'b1; redirect_target = 32'h100;
      tick();
      trap_valid = 1'b0; redirect_valid = 1'b0;
      checks++; if (imem_addr !== 32'h80) begin errors++; $display("FAIL trap_prio got a=%h exp 80", imem_addr); end
      checks++; if (if_valid !== 1'b0 || if_pc !== 32'h10) begin errors++; $display("FAIL trap_flush got ifv=%b ifpc=%h exp ifv=0 ifpc=10", if_valid, if_pc); end
      tick();
      checks++; if (imem_addr !== 32'h84 || if_pc !== 32'h80 || if_valid !== 1'b1) begin errors++; $display("FAIL trap_next got a=%h ifpc=%h ifv=%b exp a=84 ifpc=80 ifv=1", imem_addr, if_pc, if_valid); end
      $display("test_trap_redirect: done");
   endtask

   task automatic test_halt();
      do_redirect(32'h20);
      checks++; if (imem_addr !== 32'h20) begin errors++; $display("FAIL halt_setup got a=%h exp 20", imem_addr); end
      halt = 1'b1;
      tick();
      halt = 1'b0;
      checks++; if (halted !== 1'b1 || imem_req_valid !== 1'b0 || imem_addr !== 32'h24 || if_pc !== 32'h20) begin errors++; $display("FAIL halt_enter got h=%b v=%b a=%h ifpc=%h exp h=1 v=0 a=24 ifpc=20", halted, imem_req_valid, imem_addr, if_pc); end
      tick();
      checks++; if (halted !== 1'b1 || imem_req_valid !== 1'b0 || if_valid !== 1'b0) begin errors++; $display("FAIL halt_idle got h=%b v=%b ifv=%b exp h=1 v=0 ifv=0", halted, imem_req_valid, if_valid); end
      do_redirect(32'h40);
      checks++; if (halted !== 1'b1 || imem_req_valid !== 1'b0 || imem_addr !== 32'h40) begin errors++; $display("FAIL halt_redirect got h=%b v=%b a=%h exp h=1 v=0 a=40", halted, imem_req_valid, imem_addr); end
      resume = 1'b1;
      tick();
      resume = 1'b0;
      checks++; if (halted !== 1'b0 || imem_req_valid !== 1'b1 || imem_addr !== 32'h40) begin errors++; $display("FAIL resume got h=%b v=%b a=%h exp h=0 v=1 a=40", halted, imem_req_valid, imem_addr); end
      tick();
      checks++; if (imem_addr !== 32'h44 || if_pc !== 32'h40 || if_valid !== 1'b1) begin errors++; $display("FAIL resume_fetch got a=%h ifpc=%h ifv=%b exp a=44 ifpc=40 ifv=1", imem_addr, if_pc, if_valid); end
      $display("test_halt: done");
   endtask

   task automatic test_halt_resume_together();
      halt = 1'b1; resume = 1'b1;
      tick();
      checks++; if (halted !== 1'b1) begin errors++; $display("FAIL hr_run_to_halt got h=%b exp 1", halted); end
      tick();
      checks++; if (halted !== 1'b0) begin errors++; $display("FAIL hr_halt_to_run got h=%b exp 0", halted); end
      halt = 1'b0; resume = 1'b0;
      $display("test_halt_resume_together: done");
   endtask

   task automatic test_stall();
      do_redirect(32'h300);
      tick();
      checks++; if (imem_addr !== 32'h304 || if_pc !== 32'h300 || if_valid !== 1'b1) begin errors++; $display("FAIL stall_setup got a=%h ifpc=%h ifv=%b exp a=304 ifpc=300 ifv=1", imem_addr, if_pc, if_valid); end
      stall = 1'b1;
      #1;
      checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL stall_no_req got v=%b exp 0", imem_req_valid); end
      tick(); tick();
      checks++; if (imem_addr !== 32'h304 || if_pc !== 32'h300 || if_valid !== 1'b1) begin errors++; $display("FAIL stall_hold got a=%h ifpc=%h ifv=%b exp a=304 ifpc=300 ifv=1", imem_addr, if_pc, if_valid); end
      do_redirect(32'h400);
      checks++; if (imem_addr !== 32'h400 || if_valid !== 1'b0) begin errors++; $display("FAIL stall_redirect got a=%h ifv=%b exp a=400 ifv=0", imem_addr, if_valid); end
      stall = 1'b0;
      tick();
      checks++; if (imem_addr !== 32'h404 || if_pc !== 32'h400 || if_valid !== 1'b1) begin errors++; $display("FAIL stall_release got a=%h ifpc=%h ifv=%b exp a=404 ifpc=400 ifv=1", imem_addr, if_pc, if_valid); end
      $display("test_stall: done");
   endtask

   task automatic test_wrap();
      do_redirect(32'hFFFF_FFFC);
      checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_setup got a=%h exp fffffffc", imem_addr); end
      tick();
      checks++; if (imem_addr !== 32'h0 || if_pc !== 32'hFFFF_FFFC || if_valid !== 1'b1) begin errors++; $display("FAIL wrap got a=%h ifpc=%h ifv=%b exp a=0 ifpc=fffffffc ifv=1", imem_addr, if_pc, if_valid); end
      $display("test_wrap: done");
   endtask

   task automatic test_misalign();
      do_redirect(32'h200);
      do_redirect(32'h102);
`ifdef PC_MISALIGN_TRAP_EN
      checks++; if (imem_addr !== 32'h200 || if_valid !== 1'b0) begin errors++; $display("FAIL mis_hold got a=%h ifv=%b exp a=200 ifv=0", imem_addr, if_valid); end
      checks++; if (misalign_exc !== 1'b1 || misalign_addr !== 32'h102) begin errors++; $display("FAIL mis_exc got e=%b ma=%h exp e=1 ma=102", misalign_exc, misalign_addr); end
      tick();
      checks++; if (misalign_exc !== 1'b0 || imem_addr !== 32'h204) begin errors++; $display("FAIL mis_pulse got e=%b a=%h exp e=0 a=204", misalign_exc, imem_addr); end
`else
      checks++; if (imem_addr !== 32'h100 || if_valid !== 1'b0) begin errors++; $display("FAIL mis_align got a=%h ifv=%b exp a=100 ifv=0", imem_addr, if_valid); end
      tick();
      checks++; if (imem_addr !== 32'h104 || if_pc !== 32'h100) begin errors++; $display("FAIL mis_next got a=%h ifpc=%h exp a=104 ifpc=100", imem_addr, if_pc); end
`endif
      $display("test_misalign: done");
   endtask

   task automatic test_reset_mid_request();
      do_redirect(32'h500);
      tick();
      imem_req_ready = 1'b0;
      #1;
      checks++; if (imem_req_valid !== 1'b1 || if_valid !== 1'b1 || imem_addr !== 32'h504) begin errors++; $display("FAIL mid_setup got v=%b ifv=%b a=%h exp v=1 ifv=1 a=504", imem_req_valid, if_valid, imem_addr); end
      reset = 1'b0;
      #1;
      checks++; if (imem_req_valid !== 1'b0 || imem_addr !== 32'h0 || if_valid !== 1'b0 || if_pc !== 32'h0 || halted !== 1'b0) begin errors++; $display("FAIL mid_reset got v=%b a=%h ifv=%b ifpc=%h h=%b exp all 0", imem_req_valid, imem_addr, if_valid, if_pc, halted); end
      tick();
      reset = 1'b1;
      imem_req_ready = 1'b1;
      #1;
      checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL mid_boot got v=%b exp 0", imem_req_valid); end
      tick();
      checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL mid_restart got v=%b a=%h exp v=1 a=0", imem_req_valid, imem_addr); end
      $display("test_reset_mid_request: done");
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_backpressure();
      test_trap_redirect();
      test_halt();
      test_halt_resume_together();
      test_stall();
      test_wrap();
      test_misalign();
      test_reset_mid_request();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
